// File: rtl/mcu_boot_loader_pkg.sv
// Shared definitions for the MCU boot loader.
//   - boot_state_e : loader FSM states
//   - IMEM_ADDR_WIDTH / WORD_BYTES : instruction memory geometry
package mcu_boot_loader_pkg;

  localparam int IMEM_ADDR_WIDTH = 8;
  localparam int WORD_BYTES      = 4;

  typedef enum logic [2:0] {
    ST_LEN_LO = 3'd0,  // waiting for word count, low byte
    ST_LEN_HI = 3'd1,  // waiting for word count, high byte, then range check
    ST_DATA   = 3'd2,  // streaming image words into imem
    ST_DONE   = 3'd3,  // image written, core released
    ST_ERROR  = 3'd4   // image larger than imem, core held in reset
  } boot_state_e;

endpackage

// File: rtl/mcu_boot_loader_if.sv
// Boot loader bus bundle: upstream byte stream (valid/ready) plus the
// instruction-memory write port.
//   master : the loader side (accepts bytes, drives imem writes)
//   slave  : the environment side (sources bytes, receives imem writes)
interface mcu_boot_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic [7:0]            s_data;
  logic                  s_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;

  modport master (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mcu_boot_loader_byte_to_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
//   clk, rst     : clock, asynchronous active-low reset
//   byte_data    : incoming byte
//   accept       : byte_data is consumed this cycle
//   word         : completed word (valid only while word_valid is high)
//   word_valid   : combinational pulse on the accept of the 4th byte
module byte_to_word_packer
  import mcu_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_data,
  input  logic        accept,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx_q;
  // Only the first three bytes need storage; the fourth is taken straight
  // from the input so the word is complete on the same edge it is accepted.
  logic [23:0] asm_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (accept) begin
      idx_q <= idx_q + 2'd1;  // wraps 3 -> 0
      case (idx_q)
        2'd0:    asm_q[7:0]   <= byte_data;
        2'd1:    asm_q[15:8]  <= byte_data;
        2'd2:    asm_q[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

  assign word_valid = accept && (idx_q == 2'(WORD_BYTES - 1));
  assign word       = {byte_data, asm_q};

endmodule

// File: rtl/mcu_boot_loader.sv
// Streams a program image into instruction memory and holds the core in
// reset until the image is complete.
// Image: 16-bit word count N (LSB first), then N 32-bit words, LSB first.
//   clk, rst   : clock, asynchronous active-low reset
//   reload     : restart loading; honoured only in DONE/ERROR
//   core_rst   : active-high reset for the MCU core
//   boot_done  : image fully written, core running
//   boot_err   : N exceeds imem capacity, core held in reset
//   bus        : byte stream in (s_valid/s_data/s_ready), imem write out
module mcu_boot_loader
  import mcu_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  output logic              core_rst,
  output logic              boot_done,
  output logic              boot_err,
  mcu_boot_loader_if.master bus
);

  // Capacity in words, one bit wider than N so 2**16 is representable.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  boot_state_e state_q, state_d;
  logic [15:0] n_q, n_d;          // word count from the header
  logic [15:0] cnt_q, cnt_d;      // words handed to imem so far
  logic        hdr_q, hdr_d;      // header complete, range check pending
  logic        s_ready_q, s_ready_d;
  logic        imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [DATA_WIDTH-1:0] imem_wdata_q;
  logic        core_rst_q, boot_done_q, boot_err_q;

  logic        accept;
  logic [31:0] word;
  logic        word_valid;

  assign accept = bus.s_valid && s_ready_q;

  byte_to_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_data  (bus.s_data),
    .accept     (accept && (state_q == ST_DATA)),
    .word       (word),
    .word_valid (word_valid)
  );

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;

    unique case (state_q)
      ST_LEN_LO: begin
        if (accept) begin
          n_d[7:0] = bus.s_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        // The range check runs one cycle after the high byte lands, on the
        // registered count, with s_ready already low.
        if (hdr_q) begin
          hdr_d = 1'b0;
          if (n_q == 16'd0)                state_d = ST_DONE;
          else if ({1'b0, n_q} > CAPACITY) state_d = ST_ERROR;
          else                             state_d = ST_DATA;
        end else if (accept) begin
          n_d[15:8] = bus.s_data;
          hdr_d     = 1'b1;
        end
      end
      ST_DATA: begin
        if (word_valid) cnt_d = cnt_q + 16'd1;
        // All words counted means the last strobe is on the bus right now.
        if (cnt_q == n_q) state_d = ST_DONE;
      end
      ST_DONE, ST_ERROR: begin
        if (reload) begin
          state_d = ST_LEN_LO;
          n_d     = '0;
          cnt_d   = '0;
          hdr_d   = 1'b0;
        end
      end
      default: state_d = ST_LEN_LO;
    endcase

    // Ready is a register, so it is derived from where the FSM goes next.
    // It drops as soon as the final word's 4th byte is taken so no spare
    // byte (and no spare write) can follow.
    s_ready_d = (state_d == ST_LEN_LO) ||
                ((state_d == ST_LEN_HI) && !hdr_d) ||
                ((state_d == ST_DATA) && (cnt_d != n_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_LEN_LO;
      n_q          <= '0;
      cnt_q        <= '0;
      hdr_q        <= 1'b0;
      s_ready_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      boot_done_q  <= 1'b0;
      boot_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      s_ready_q   <= s_ready_d;
      imem_we_q   <= word_valid;
      if (word_valid) begin
        imem_addr_q  <= cnt_q[ADDR_WIDTH-1:0];
        imem_wdata_q <= DATA_WIDTH'(word);
      end
      core_rst_q  <= (state_d != ST_DONE);
      boot_done_q <= (state_d == ST_DONE);
      boot_err_q  <= (state_d == ST_ERROR);
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_rst       = core_rst_q;
  assign boot_done      = boot_done_q;
  assign boot_err       = boot_err_q;

endmodule

// File: tb/tb_mcu_boot_loader.sv
// Directed bench for mcu_boot_loader with an imem-write scoreboard.
module tb_mcu_boot_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reload = 1'b0;
  logic core_rst, boot_done, boot_err;

  int total = 0;
  int bad = 0;
  int we_count = 0;
  bit throttle = 1'b0;
  bit word_done_evt = 1'b0;
  wr_t exp_q[$];

  mcu_boot_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  mcu_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .reload    (reload),
    .core_rst  (core_rst),
    .boot_done (boot_done),
    .boot_err  (boot_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard and strobe-timing monitor: a strobe must appear exactly in
  // the cycle after each word-completing handshake.
  always @(negedge clk) begin
    if (rst) begin
      check("we_timing", 32'(bus.imem_we), 32'(word_done_evt));
      word_done_evt = 1'b0;
      if (bus.imem_we === 1'b1) begin
        we_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_we", 32'(1), 32'(0));
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("imem_addr", 32'(bus.imem_addr), 32'(e.addr));
          check("imem_wdata", bus.imem_wdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last_of_word);
    bit r;
    int n;
    r = 1'b0;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    do begin
      @(negedge clk);
      r = bus.s_ready;
      tick();
      n++;
    end while (!r && n < 40);
    if (!r) check("handshake_timeout", 32'(0), 32'(1));
    if (last_of_word) word_done_evt = 1'b1;
    if (throttle) begin
      bus.s_valid = 1'b0;
      bus.s_data  = 8'($urandom);
      tick();
    end
  endtask

  task automatic send_header(input logic [15:0] n);
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0], 1'b0);
    send_byte(w[15:8], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[31:24], 1'b1);
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] w);
    exp_q.push_back('{addr: addr, data: w});
    send_word(w);
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic crst,
                              input logic done, input logic err);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 32'(rdy));
    check({tag, "_core_rst"}, 32'(core_rst), 32'(crst));
    check({tag, "_boot_done"}, 32'(boot_done), 32'(done));
    check({tag, "_boot_err"}, 32'(boot_err), 32'(err));
  endtask

  task automatic check_reset_values(input string tag);
    check_status(tag, 1'b0, 1'b1, 1'b0, 1'b0);
    check({tag, "_imem_we"}, 32'(bus.imem_we), 32'(0));
    check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'(0));
    check({tag, "_imem_wdata"}, bus.imem_wdata, 32'(0));
  endtask

  // Final word's strobe cycle, then the cycle in which the core is released.
  task automatic finish_load(input string tag);
    bus.s_valid = 1'b0;
    @(negedge clk);
    check({tag, "_strobe_core_rst"}, 32'(core_rst), 32'(1));
    @(negedge clk);
    check_status(tag, 1'b0, 1'b0, 1'b1, 1'b0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    @(negedge clk);
    check_status("reload", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // Reset values, then idle stream after release.
    #12;
    check_reset_values("in_reset");
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("first_cycle_s_ready", 32'(bus.s_ready), 32'(0));
    repeat (4) @(negedge clk);
    check_status("idle", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // Two-word image, back-to-back bytes.
    send_header(16'd2);
    load_word(8'd0, 32'h00500013);
    load_word(8'd1, 32'h00100093);
    finish_load("b2b");

    // Same image with s_valid toggled every other cycle.
    pulse_reload();
    throttle = 1'b1;
    send_header(16'd2);
    load_word(8'd0, 32'h00500013);
    load_word(8'd1, 32'h00100093);
    throttle = 1'b0;
    // The throttled sender already spent the strobe cycle idling.
    @(negedge clk);
    check_status("throttle", 1'b0, 1'b0, 1'b1, 1'b0);
    check("throttle_queue_empty", 32'(exp_q.size()), 32'(0));
    tick();

    // Empty image: DONE two cycles after the high-byte handshake.
    pulse_reload();
    send_header(16'd0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    check("n0_not_yet_done", 32'(boot_done), 32'(0));
    @(negedge clk);
    check_status("n0", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Oversized image: N = 257.
    pulse_reload();
    send_header(16'h0101);
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_status("n257", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    pulse_reload();

    // Full-capacity image; a reload pulse mid-load must be ignored.
    send_header(16'd256);
    for (int i = 0; i < 256; i++) begin
      if (i == 100) reload = 1'b1;
      load_word(8'(i), {8'(i), 8'(~i), 8'(i + 3), 8'h5A});
      reload = 1'b0;
    end
    finish_load("n256");
    check("n256_strobes", 32'(we_count), 32'(2 + 2 + 256));
    repeat (3) @(negedge clk);
    check("n256_no_extra_strobe", 32'(we_count), 32'(260));
    tick();

    // Reload with a one-word image.
    pulse_reload();
    send_header(16'd1);
    load_word(8'd0, 32'hEFBEADDE);
    finish_load("n1");
    tick();

    // Async reset while the first word's strobe is on the bus.
    pulse_reload();
    send_header(16'd2);
    send_word(32'h11223344);
    #1;
    rst = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    check_reset_values("async_rst");
    word_done_evt = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_again_first_s_ready", 32'(bus.s_ready), 32'(0));
    tick();
    send_header(16'd1);
    load_word(8'd0, 32'hCAFEF00D);
    finish_load("after_rst");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so a stalled handshake can never hang the run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
